// File: rtl/serial_pattern_detector.sv
// Serial pattern detector. It takes one bit on each enabled clock edge and looks for
// a LEN-bit PATTERN. Matches may overlap. It gives a registered one-cycle match pulse
// and keeps a saturating count of matches.
module serial_pattern_detector #(
  parameter int unsigned       LEN     = 4,
  parameter logic [LEN-1:0]    PATTERN = 4'b1011,
  parameter int unsigned       CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic             din,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat,
  output logic             armed
);

  localparam int unsigned       FILL_W    = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_PRE   = CNT_MAX - CNT_W'(1);

  typedef enum logic [0:0] {
    StFill,
    StArmed
  } state_e;

  state_e             r_state;
  logic [LEN-1:0]     r_sr;
  logic [FILL_W-1:0]  r_fill_cnt;
  logic               r_match;
  logic [CNT_W-1:0]   r_count;
  logic               r_sat;
  logic               r_armed;

  logic [LEN-1:0]     w_sr_next;
  logic               w_last_fill;
  logic               w_armed_next;
  logic               w_hit;

  // Window after this edge's bit is shifted in. This edge may arm the detector and
  // match at the same time.
  always_comb begin
    w_sr_next    = {r_sr[LEN-2:0], din};
    w_last_fill  = (r_state == StFill) && (r_fill_cnt == FILL_LAST);
    w_armed_next = (r_state == StArmed) || w_last_fill;
    w_hit        = w_armed_next && (w_sr_next == PATTERN);
  end

  // Detector FSM, shift register, match pulse and saturating counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= StFill;
      r_sr       <= '0;
      r_fill_cnt <= '0;
      r_match    <= 1'b0;
      r_count    <= '0;
      r_sat      <= 1'b0;
      r_armed    <= 1'b0;
    end else if (clear) begin
      r_state    <= StFill;
      r_sr       <= '0;
      r_fill_cnt <= '0;
      r_match    <= 1'b0;
      r_count    <= '0;
      r_sat      <= 1'b0;
      r_armed    <= 1'b0;
    end else if (en) begin
      r_sr    <= w_sr_next;
      r_match <= w_hit;
      unique case (r_state)
        StFill: begin
          if (w_last_fill) begin
            r_state <= StArmed;
            r_armed <= 1'b1;
          end else begin
            r_fill_cnt <= r_fill_cnt + 1'b1;
          end
        end
        StArmed: begin
          r_state <= StArmed;
        end
        default: begin
          r_state <= StFill;
        end
      endcase
      if (w_hit) begin
        if (r_count != CNT_MAX) begin
          r_count <= r_count + 1'b1;
        end
        // count_sat rises on the same edge as the count reaches its maximum.
        if ((r_count == CNT_PRE) || (r_count == CNT_MAX)) begin
          r_sat <= 1'b1;
        end
      end
    end else begin
      r_match <= 1'b0;
    end
  end

  assign match       = r_match;
  assign match_count = r_count;
  assign count_sat   = r_sat;
  assign armed       = r_armed;

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Self-checking bench for serial_pattern_detector. Instance 0 uses the default 1011
// pattern with an 8-bit counter. Instance 1 uses pattern 0000 with a 3-bit counter.
// Each instance is checked against a history-based reference model.
module tb_serial_pattern_detector;

  logic       clk;
  logic       rst_n;
  logic       en0, clr0, din0;
  logic       en1, clr1, din1;
  logic       match0, sat0, armed0;
  logic [7:0] cnt0;
  logic       match1, sat1, armed1;
  logic [2:0] cnt1;

  int tests;
  int fails;

  // Reference model. It keeps the number of bits since reset or clear, a window of
  // the last four bits, and the total number of matches.
  int          m_n[2];
  int unsigned m_win[2];
  int          m_hits[2];
  bit          m_match[2];
  int unsigned m_pat[2] = '{32'hB, 32'h0};
  int          m_max[2] = '{255, 7};

  serial_pattern_detector #(
    .LEN(4), .PATTERN(4'b1011), .CNT_W(8)
  ) u_dut0 (
    .clk(clk), .reset(rst_n), .en(en0), .clear(clr0), .din(din0),
    .match(match0), .match_count(cnt0), .count_sat(sat0), .armed(armed0)
  );

  serial_pattern_detector #(
    .LEN(4), .PATTERN(4'b0000), .CNT_W(3)
  ) u_dut1 (
    .clk(clk), .reset(rst_n), .en(en1), .clear(clr1), .din(din1),
    .match(match1), .match_count(cnt1), .count_sat(sat1), .armed(armed1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clr(input int i);
    m_n[i]     = 0;
    m_win[i]   = 0;
    m_hits[i]  = 0;
    m_match[i] = 1'b0;
  endtask

  task automatic model_edge(input int i, input bit e, input bit c, input bit d);
    if (!rst_n || c) begin
      model_clr(i);
    end else if (e) begin
      if (m_n[i] < 64) m_n[i]++;
      m_win[i]   = ((m_win[i] << 1) | 32'(d)) & 32'hF;
      m_match[i] = (m_n[i] >= 4) && (m_win[i] == m_pat[i]);
      if (m_match[i]) m_hits[i]++;
    end else begin
      m_match[i] = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    int c0, c1;
    c0 = (m_hits[0] > m_max[0]) ? m_max[0] : m_hits[0];
    c1 = (m_hits[1] > m_max[1]) ? m_max[1] : m_hits[1];
    chk($sformatf("%s_d0_match", tag), 32'(match0), 32'(m_match[0]));
    chk($sformatf("%s_d0_count", tag), 32'(cnt0), 32'(c0));
    chk($sformatf("%s_d0_sat", tag), 32'(sat0), 32'(m_hits[0] >= m_max[0]));
    chk($sformatf("%s_d0_armed", tag), 32'(armed0), 32'(m_n[0] >= 4));
    chk($sformatf("%s_d1_match", tag), 32'(match1), 32'(m_match[1]));
    chk($sformatf("%s_d1_count", tag), 32'(cnt1), 32'(c1));
    chk($sformatf("%s_d1_sat", tag), 32'(sat1), 32'(m_hits[1] >= m_max[1]));
    chk($sformatf("%s_d1_armed", tag), 32'(armed1), 32'(m_n[1] >= 4));
  endtask

  // One rising edge. The model advances on the edge and outputs are checked 1 ns later.
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge(0, en0, clr0, din0);
    model_edge(1, en1, clr1, din1);
    #1;
    check_all(tag);
  endtask

  task automatic drive0(input bit e, input bit d, input bit c);
    en0 = e; din0 = d; clr0 = c;
  endtask

  task automatic drive1(input bit e, input bit d, input bit c);
    en1 = e; din1 = d; clr1 = c;
  endtask

  initial begin
    logic [6:0] seq7;
    tests = 0;
    fails = 0;
    model_clr(0);
    model_clr(1);
    drive0(1'b0, 1'b0, 1'b0);
    drive1(1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;

    // Reset held for two edges.
    tick("rst");
    tick("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // 1,0,1,1 then 0,1,1: overlapping matches after bits 4 and 7.
    seq7 = 7'b1011011;
    for (int k = 6; k >= 0; k--) begin
      @(negedge clk);
      drive0(1'b1, seq7[k], 1'b0);
      tick("ovl");
      if (k == 3) begin
        chk("tp_arm4", 32'(armed0), 32'd1);
        chk("tp_match4", 32'(match0), 32'd1);
        chk("tp_cnt4", 32'(cnt0), 32'd1);
      end
    end
    chk("tp_cnt7", 32'(cnt0), 32'd2);
    @(negedge clk);
    drive0(1'b0, 1'b0, 1'b0);
    tick("ovl_idle");
    chk("tp_ovl_after", 32'(match0), 32'd0);

    // All-zero pattern: no match during fill, then a match every cycle, saturating at 7.
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      drive1(1'b1, 1'b0, 1'b0);
      tick("zero");
      if (k < 3) chk("tp_zero_fill", 32'(match1), 32'd0);
    end
    chk("tp_sat_cnt", 32'(cnt1), 32'd7);
    chk("tp_sat_flag", 32'(sat1), 32'd1);
    @(negedge clk);
    drive1(1'b1, 1'b0, 1'b1);
    tick("clr1");
    chk("tp_clr_cnt", 32'(cnt1), 32'd0);
    chk("tp_clr_armed", 32'(armed1), 32'd0);
    @(negedge clk);
    drive1(1'b0, 1'b0, 1'b0);

    // Disabled cycles in the middle of a pattern.
    @(negedge clk);
    drive0(1'b1, 1'b0, 1'b1);
    tick("clr0");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive0(1'b1, k[0] ? 1'b0 : 1'b1, 1'b0);
      tick("dis_pre");
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive0(1'b0, k[0], 1'b0);
      tick("dis");
    end
    @(negedge clk);
    drive0(1'b1, 1'b1, 1'b0);
    tick("dis_post");
    chk("tp_dis_match", 32'(match0), 32'd1);
    chk("tp_dis_cnt", 32'(cnt0), 32'd1);

    // Asynchronous reset pulse between edges after 1,0,1.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive0(1'b1, k[0] ? 1'b0 : 1'b1, 1'b0);
      tick("ar_pre");
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_clr(0);
    model_clr(1);
    check_all("ar_now");
    chk("tp_ar_armed", 32'(armed0), 32'd0);
    #1 rst_n = 1'b1;
    drive0(1'b1, 1'b1, 1'b0);
    tick("ar_one");
    chk("tp_ar_nomatch", 32'(match0), 32'd0);
    seq7 = 7'b0000011;
    for (int k = 2; k >= 0; k--) begin
      @(negedge clk);
      drive0(1'b1, seq7[k], 1'b0);
      tick("ar_rest");
    end
    chk("tp_ar_match", 32'(match0), 32'd1);

    // Random traffic on both instances.
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      drive0($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 63) == 0);
      drive1($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 63) == 0);
      tick("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
